// File: rtl/fb_scanout_arbiter_if.sv
// fb_scanout_arbiter_if: framebuffer RAM port plus draw-engine write channel
interface fb_scanout_arbiter_if #(
  parameter int AW = 15,
  parameter int DW = 4
);
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          drw_valid;
  logic          drw_ready;
  logic [AW-1:0] drw_addr;
  logic [DW-1:0] drw_data;
  modport master (
    output mem_addr, mem_we, mem_wdata, drw_ready,
    input  mem_rdata, drw_valid, drw_addr, drw_data
  );
  modport slave (
    input  mem_addr, mem_we, mem_wdata, drw_ready,
    output mem_rdata, drw_valid, drw_addr, drw_data
  );
endinterface

// File: rtl/fb_scanout_arbiter.sv
// fb_scanout_arbiter: shares the framebuffer RAM between row prefetch and draw writes, serves upscaled pixels; FB_ARB_STATS_EN adds the draw stall counter
module fb_scanout_arbiter #(
  parameter int H_RES      = 800,
  parameter int V_RES      = 600,
  parameter int SCALE_LOG2 = 2,
  parameter int DW         = 4,
  parameter int AW         = 15
) (
  input  logic                 clk_pix,
  input  logic                 rst_pix,
  input  logic [9:0]           sx,
  input  logic [9:0]           sy,
  input  logic                 de,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic                 frame,
  fb_scanout_arbiter_if.master bus,
  output logic [DW-1:0]        pix,
  output logic                 de_q,
  output logic                 hsync_q,
  output logic                 vsync_q,
  output logic                 fetch_busy,
  output logic                 overrun,
  output logic [15:0]          stall_cnt
);
  localparam int FB_W = H_RES >> SCALE_LOG2;
  localparam int FB_H = V_RES >> SCALE_LOG2;
  localparam int CW = $clog2(FB_W);
  localparam logic [9:0] V_END = 10'(V_RES);
  localparam logic [9:0] ROW_LAST = 10'(FB_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(FB_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] row_base;
  logic [CW-1:0] col, wr_col, rd_col;
  logic fbank, wr_en, trig, grant;
  logic [9:0] sy_row;
  logic [DW-1:0] lb [2][FB_W];

  assign sy_row = sy >> SCALE_LOG2;
  assign rd_col = CW'(sx >> SCALE_LOG2);
  assign trig = sx == '0 && (sy == V_END || (sy < V_END && sy[SCALE_LOG2-1:0] == '0 && sy_row < ROW_LAST));
  assign fetch_busy = state != IDLE;

  // fetch FSM state register
  always_ff @(posedge clk_pix) state <= rst_pix ? IDLE : state_nxt;

  // next state and RAM port mux; draw is granted only when idle and no fetch is starting
  always_comb begin
    state_nxt = state == IDLE ? (trig ? FETCH : IDLE) : state == FETCH ? (col == COL_LAST ? DRAIN : FETCH) : IDLE;
    bus.drw_ready = !rst_pix && state == IDLE && !trig;
    grant = bus.drw_ready && bus.drw_valid;
    bus.mem_we = grant;
    bus.mem_addr = grant ? bus.drw_addr : (!rst_pix && state == FETCH) ? row_base + AW'(col) : '0;
    bus.mem_wdata = grant ? bus.drw_data : '0;
  end

  // fetch column walk, running row base, target bank and sticky overrun
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      row_base <= '0;
      col <= '0;
      fbank <= 1'b0;
      wr_en <= 1'b0;
      wr_col <= '0;
      overrun <= 1'b0;
    end else begin
      if (trig && state == IDLE) begin
        row_base <= sy == V_END ? '0 : row_base + AW'(FB_W);
        fbank <= sy == V_END ? 1'b0 : ~sy[SCALE_LOG2];
        col <= '0;
      end else if (state == FETCH) col <= col + 1'b1;
      wr_en <= state == FETCH;
      wr_col <= col;
      if (trig && state != IDLE) overrun <= 1'b1;
    end
  end

  // line buffer capture; RAM data trails its address by one cycle
  always_ff @(posedge clk_pix) if (wr_en) lb[fbank][wr_col] <= bus.mem_rdata;

  // scanout stage: pixel lookup registered alongside the delayed timing signals
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      pix <= '0;
      de_q <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      pix <= de ? lb[sy[SCALE_LOG2]][rd_col] : '0;
      de_q <= de;
      hsync_q <= hsync_in;
      vsync_q <= vsync_in;
    end
  end

`ifdef FB_ARB_STATS_EN
  logic [15:0] stall_acc, stall_inc;
  assign stall_inc = stall_acc + 16'(bus.drw_valid && !bus.drw_ready && stall_acc != 16'hFFFF);

  // saturating stall accumulator, published and cleared on each frame pulse
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      stall_acc <= '0;
      stall_cnt <= '0;
    end else if (frame) begin
      stall_acc <= '0;
      stall_cnt <= stall_inc;
    end else stall_acc <= stall_inc;
  end
`else
  logic unused_frame;
  assign unused_frame = frame;
  assign stall_cnt = '0;
`endif
endmodule
